// File: rtl/seg_pkg.sv
// Shared constants and helpers for the four-digit seven-segment display controller.
package seg_pkg;
    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 2;
    localparam int MASK_W     = 4;
    localparam int BYTE_W     = 8;
    localparam int DATA_W     = MASK_W * BYTE_W;
    localparam int PB_W       = 2 * NUM_DIGITS;

    // Byte-wise merge: each set mask bit replaces the matching byte of cur.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] cur,
        input logic [DATA_W-1:0] upd,
        input logic [MASK_W-1:0] mask
    );
        logic [DATA_W-1:0] res;
        res = cur;
        for (int b = 0; b < MASK_W; b++) begin
            if (mask[b]) res[b*BYTE_W +: BYTE_W] = upd[b*BYTE_W +: BYTE_W];
        end
        return res;
    endfunction
endpackage

// File: rtl/scan_timer.sv
// Digit-scan timebase: prescaler, digit index, frame counter and blink phase.
module scan_timer
    import seg_pkg::*;
#(
    parameter int SCAN_DIV_W   = 16,
    parameter int FLASH_FRAMES = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               o_tick,
    output logic               o_frame_boundary,
    output logic               o_frame_start,
    output logic [DIGIT_W-1:0] o_scanning,
    output logic               o_flash_clk
);
    logic [SCAN_DIV_W-1:0] r_prescale;
    logic [DIGIT_W-1:0]    r_scanning;
    logic [7:0]            r_frame_cnt;
    logic                  r_flash_clk;
    logic                  r_frame_start;
    logic                  w_tick;
    logic                  w_frame_boundary;

    assign w_tick           = &r_prescale;
    assign w_frame_boundary = w_tick && (r_scanning == DIGIT_W'(NUM_DIGITS - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prescale    <= '0;
            r_scanning    <= '0;
            r_frame_cnt   <= '0;
            r_flash_clk   <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_prescale    <= r_prescale + SCAN_DIV_W'(1);
            r_frame_start <= w_frame_boundary;
            if (w_tick) r_scanning <= r_scanning + DIGIT_W'(1);
            if (w_frame_boundary) begin
                if (r_frame_cnt == 8'(FLASH_FRAMES - 1)) begin
                    r_frame_cnt <= '0;
                    r_flash_clk <= ~r_flash_clk;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end
            end
        end
    end

    assign o_tick           = w_tick;
    assign o_frame_boundary = w_frame_boundary;
    assign o_frame_start    = r_frame_start;
    assign o_scanning       = r_scanning;
    assign o_flash_clk      = r_flash_clk;
endmodule

// File: rtl/seg_disp_ctrl.sv
// Seven-segment display controller: shadowed number/point/blink registers that
// commit only at scan-frame boundaries so the display never tears.
module seg_disp_ctrl
    import seg_pkg::*;
#(
    parameter int SCAN_DIV_W   = 16,
    parameter int FLASH_FRAMES = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic [MASK_W-1:0]  wr_mask,
    input  logic               pb_wr_en,
    input  logic [PB_W-1:0]    pb_data,
    output logic [DATA_W-1:0]  disp_num,
    output logic [NUM_DIGITS-1:0] pointing,
    output logic [NUM_DIGITS-1:0] blinking,
    output logic [DIGIT_W-1:0] Scanning,
    output logic               flash_clk,
    output logic               frame_start,
    output logic               pending
);
    logic              w_tick;
    logic              w_frame_boundary;
    logic              w_write;
    logic [DATA_W-1:0] w_shadow_next;
    logic [PB_W-1:0]   w_pb_next;

    logic [DATA_W-1:0]     r_shadow;
    logic [PB_W-1:0]       r_pb_shadow;
    logic [DATA_W-1:0]     r_disp_num;
    logic [NUM_DIGITS-1:0] r_pointing;
    logic [NUM_DIGITS-1:0] r_blinking;
    logic                  r_pending;

    scan_timer #(
        .SCAN_DIV_W  (SCAN_DIV_W),
        .FLASH_FRAMES(FLASH_FRAMES)
    ) u_scan_timer (
        .clk             (clk),
        .rst_n           (rst_n),
        .o_tick          (w_tick),
        .o_frame_boundary(w_frame_boundary),
        .o_frame_start   (frame_start),
        .o_scanning      (Scanning),
        .o_flash_clk     (flash_clk)
    );

    // Merged shadow values feed both the shadow registers and the commit path,
    // so a write landing in the boundary cycle is part of that commit.
    always_comb begin
        w_shadow_next = r_shadow;
        w_pb_next     = r_pb_shadow;
        if (wr_en)    w_shadow_next = merge_bytes(r_shadow, wr_data, wr_mask);
        if (pb_wr_en) w_pb_next     = pb_data;
    end

    assign w_write = wr_en || pb_wr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: shadows are reset too, so a reset mid-frame drops uncommitted data.
            r_shadow    <= '0;
            r_pb_shadow <= '0;
            r_disp_num  <= '0;
            r_pointing  <= '0;
            r_blinking  <= '0;
            r_pending   <= 1'b0;
        end else begin
            r_shadow    <= w_shadow_next;
            r_pb_shadow <= w_pb_next;
            if (w_frame_boundary) begin
                if (r_pending || w_write) begin
                    r_disp_num <= w_shadow_next;
                    r_pointing <= w_pb_next[NUM_DIGITS-1:0];
                    r_blinking <= w_pb_next[PB_W-1:NUM_DIGITS];
                end
                r_pending <= 1'b0;
            end else if (w_write) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign disp_num = r_disp_num;
    assign pointing = r_pointing;
    assign blinking = r_blinking;
    assign pending  = r_pending;

    a_boundary_on_tick: assert property (@(posedge clk) disable iff (!rst_n)
        w_frame_boundary |-> w_tick);
endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Self-checking bench for seg_disp_ctrl: directed scenarios plus random writes
// against a cycle-count based reference model.
module tb_seg_disp_ctrl;
    localparam int SCAN_DIV_W   = 2;
    localparam int FLASH_FRAMES = 2;
    localparam int TICK_CYC     = 1 << SCAN_DIV_W;
    localparam int FRAME_CYC    = 4 * TICK_CYC;
    localparam int FLASH_CYC    = FRAME_CYC * FLASH_FRAMES;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [3:0]  wr_mask;
    logic        pb_wr_en;
    logic [7:0]  pb_data;
    logic [31:0] disp_num;
    logic [3:0]  pointing;
    logic [3:0]  blinking;
    logic [1:0]  Scanning;
    logic        flash_clk;
    logic        frame_start;
    logic        pending;

    seg_disp_ctrl #(
        .SCAN_DIV_W  (SCAN_DIV_W),
        .FLASH_FRAMES(FLASH_FRAMES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_mask    (wr_mask),
        .pb_wr_en   (pb_wr_en),
        .pb_data    (pb_data),
        .disp_num   (disp_num),
        .pointing   (pointing),
        .blinking   (blinking),
        .Scanning   (Scanning),
        .flash_clk  (flash_clk),
        .frame_start(frame_start),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [31:0] m_shadow, m_disp;
    logic [7:0]  m_pb, m_pb_commit;
    bit          m_pending;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0; m_shadow = '0; m_disp = '0; m_pb = '0; m_pb_commit = '0; m_pending = 0;
    endtask

    // Reference: everything follows from the number of clock edges since reset release.
    task automatic model_edge();
        bit wrote;
        cyc++;
        if (wr_en)
            for (int b = 0; b < 4; b++)
                if (wr_mask[b]) m_shadow[8*b +: 8] = wr_data[8*b +: 8];
        if (pb_wr_en) m_pb = pb_data;
        wrote = wr_en || pb_wr_en;
        if (cyc % FRAME_CYC == 0) begin
            if (m_pending || wrote) begin
                m_disp      = m_shadow;
                m_pb_commit = m_pb;
            end
            m_pending = 0;
        end else if (wrote) begin
            m_pending = 1;
        end
    endtask

    task automatic check_all();
        check("scanning",    32'(Scanning),    32'((cyc / TICK_CYC) % 4));
        check("frame_start", 32'(frame_start), 32'(cyc > 0 && cyc % FRAME_CYC == 0));
        check("flash_clk",   32'(flash_clk),   32'((cyc / FLASH_CYC) % 2));
        check("pending",     32'(pending),     32'(m_pending));
        check("disp_num",    disp_num,         m_disp);
        check("pointing",    32'(pointing),    32'(m_pb_commit[3:0]));
        check("blinking",    32'(blinking),    32'(m_pb_commit[7:4]));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".scan"},  32'(Scanning),    32'd0);
        check({tag, ".fs"},    32'(frame_start), 32'd0);
        check({tag, ".flash"}, 32'(flash_clk),   32'd0);
        check({tag, ".pend"},  32'(pending),     32'd0);
        check({tag, ".disp"},  disp_num,         32'd0);
        check({tag, ".point"}, 32'(pointing),    32'd0);
        check({tag, ".blink"}, 32'(blinking),    32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic write(input logic [31:0] d, input logic [3:0] m);
        wr_en = 1'b1; wr_data = d; wr_mask = m;
        step();
        wr_en = 1'b0;
    endtask

    task automatic wait_phase(input int p);
        while (cyc % FRAME_CYC != p) step();
    endtask

    task automatic run_to_boundary();
        int n = 0;
        do begin
            step();
            n++;
        end while (cyc % FRAME_CYC != 0 && n < 2 * FRAME_CYC);
        if (cyc % FRAME_CYC != 0) check("boundary_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; wr_mask = '0; pb_wr_en = 1'b0; pb_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        // Idle timing
        repeat (64) step();

        // Two writes in one frame accumulate
        wait_phase(3);
        write(32'hAABBCCDD, 4'h3);
        wait_phase(9);
        write(32'h11000000, 4'h8);
        check("two_writes.disp_hold", disp_num, 32'd0);
        run_to_boundary();
        check("two_writes.commit", disp_num, 32'h1100CCDD);

        // Full write mid-frame
        wait_phase(5);
        write(32'h12345678, 4'hF);
        check("mid.pending", 32'(pending), 32'd1);
        check("mid.disp_hold", disp_num, 32'h1100CCDD);
        run_to_boundary();
        check("mid.commit", disp_num, 32'h12345678);

        // Write in the exact boundary cycle
        wait_phase(FRAME_CYC - 1);
        write(32'hDEADBEEF, 4'hF);
        check("bnd.commit", disp_num, 32'hDEADBEEF);
        check("bnd.pending", 32'(pending), 32'd0);

        // Zero mask still sets pending
        wait_phase(2);
        write(32'hFFFFFFFF, 4'h0);
        check("mask0.pending", 32'(pending), 32'd1);
        run_to_boundary();
        check("mask0.disp", disp_num, 32'hDEADBEEF);

        // Point/blink write
        wait_phase(4);
        pb_wr_en = 1'b1; pb_data = 8'hA5;
        step();
        pb_wr_en = 1'b0;
        run_to_boundary();
        check("pb.point", 32'(pointing), 32'h5);
        check("pb.blink", 32'(blinking), 32'hA);

        // Reset while pending
        wait_phase(6);
        write(32'hCAFEF00D, 4'hF);
        #2 rst_n = 1'b0;
        #1 check_zero("midrst");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        run_to_boundary();
        check("midrst.no_commit", disp_num, 32'd0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            wr_en    = ($urandom_range(0, 5) == 0);
            wr_data  = $urandom;
            wr_mask  = 4'($urandom_range(0, 15));
            pb_wr_en = ($urandom_range(0, 9) == 0);
            pb_data  = 8'($urandom_range(0, 255));
            step();
        end
        wr_en = 1'b0; pb_wr_en = 1'b0;
        run_to_boundary();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/seg_disp_ctrl.md
SEG_DISP_CTRL -- requirements
Module: seg_disp_ctrl

Interface
REQ-001 The block SHALL have parameter SCAN_DIV_W, default 16, meaning the prescaler width; one scan tick occurs every 2^SCAN_DIV_W clk cycles.
REQ-002 The block SHALL have parameter FLASH_FRAMES, default 32, meaning the number of complete scan frames per flash_clk half-period (legal range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port wr_en, input, 1 bit: display-number write strobe.
REQ-006 The block SHALL have port wr_data, input, 32 bits: display-number write data.
REQ-007 The block SHALL have port wr_mask, input, 4 bits: byte enables for wr_data; bit i enables byte i.
REQ-008 The block SHALL have port pb_wr_en, input, 1 bit: point/blink write strobe.
REQ-009 The block SHALL have port pb_data, input, 8 bits: {blinking[3:0], pointing[3:0]} write data.
REQ-010 The block SHALL have port disp_num, output, 32 bits: committed display number for the seven-segment device.
REQ-011 The block SHALL have ports pointing and blinking, outputs, 4 bits each: committed per-digit dot and blink enables.
REQ-012 The block SHALL have port Scanning, output, 2 bits: current digit index.
REQ-013 The block SHALL have port flash_clk, output, 1 bit: blink phase.
REQ-014 The block SHALL have port frame_start, output, 1 bit: one-cycle pulse at each frame boundary.
REQ-015 The block SHALL have port pending, output, 1 bit: shadow data is awaiting commit.

Function
REQ-016 The prescaler SHALL count up every cycle and wrap from 2^SCAN_DIV_W-1 to 0; the wrap cycle is the "tick".
REQ-017 On each tick, Scanning SHALL increment modulo 4 (3 -> 0).
REQ-018 A tick on which Scanning goes 3 -> 0 is a frame boundary; frame_start SHALL be 1 in the cycle after that tick, coincident with the new Scanning value 0, and 0 at all other times.
REQ-019 A frame counter SHALL count frame boundaries 0..FLASH_FRAMES-1; on its wrap, flash_clk SHALL toggle in the same cycle as the Scanning update.
REQ-020 wr_en=1 SHALL merge wr_data into a 32-bit shadow register, byte-wise per wr_mask, in one cycle, and SHALL set pending.
REQ-021 pb_wr_en=1 SHALL load an 8-bit point/blink shadow and SHALL set pending.
REQ-022 wr_en with wr_mask=0 SHALL leave the shadow unchanged but SHALL still set pending.
REQ-023 At a frame boundary with pending=1, disp_num, pointing and blinking SHALL load from the shadows in the same edge as Scanning -> 0, and pending SHALL clear.
REQ-024 A write in the frame-boundary cycle SHALL be included in the commit (the merged value is committed), and pending SHALL end at 0.
REQ-025 At a frame boundary with pending=0, the committed outputs SHALL hold.
REQ-026 Committed outputs SHALL never change except at a frame boundary (tear-free display).
REQ-027 Multiple writes within one frame SHALL accumulate; the last write to each byte wins.

Reset
REQ-028 While rst_n=0, the prescaler, Scanning, the frame counter, flash_clk, frame_start, pending, both shadows, disp_num, pointing and blinking SHALL all be 0, asynchronously.
REQ-029 Reset asserted mid-frame SHALL discard uncommitted shadow data.
REQ-030 After release of reset, the first tick SHALL occur 2^SCAN_DIV_W cycles later.

Structure
REQ-031 The package seg_pkg SHALL hold the digit-count constant (4), the digit-index width (2) and the byte-mask width (4).
REQ-032 The prescaler, Scanning counter, frame counter and flash toggle SHALL form sub-module scan_timer, which outputs tick and frame_boundary.
REQ-033 The shadow/commit logic SHALL reside in seg_disp_ctrl.

Verification (SCAN_DIV_W=2, FLASH_FRAMES=2)
REQ-034 Release reset, idle 64 cycles -> Scanning steps every 4 cycles (0,1,2,3,0...); frame_start pulses every 16 cycles; flash_clk toggles every 32 cycles.
REQ-035 Mid-frame, wr_en with wr_data=0x12345678 and mask=4'hF -> pending=1; disp_num stays 0 until the next frame boundary, then equals 0x12345678 and pending=0.
REQ-036 Two writes in one frame (0xAABBCCDD with mask 4'h3, then 0x11000000 with mask 4'h8) -> commit yields 0x1100CCDD.
REQ-037 Write 0xDEADBEEF in the exact frame-boundary cycle -> disp_num=0xDEADBEEF after that edge; pending=0.
REQ-038 pb_wr_en with pb_data=8'hA5 -> at the next boundary, pointing=4'h5 and blinking=4'hA.
REQ-039 Assert rst_n=0 while pending=1 mid-frame -> all outputs go to 0 immediately; after release, the next boundary commits nothing (disp_num=0).
